// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmit port
// between N byte-stream requesters. The owner keeps the transmitter until it
// sends a byte marked last, reaches MAXBURST bytes, or goes idle for TIMEOUT
// cycles. Every output comes straight from a register.
module uart_tx_arbiter #(
   parameter int N        = 4,
   parameter int MAXBURST = 16,
   parameter int TIMEOUT  = 1000
) (
   input  logic           SYSCLK,
   input  logic           RESET,
   input  logic [8*N-1:0] reqData,
   input  logic [N-1:0]   reqValid,
   input  logic [N-1:0]   reqLast,
   output logic [N-1:0]   reqAck,
   output logic [N-1:0]   gnt,
   output logic [7:0]     txData,
   output logic           txStb,
   input  logic           txRdy
);

   localparam int PW = $clog2(N);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GUARD
   } state_t;

   state_t        r_state,  w_state_nxt;
   logic [PW-1:0] r_ptr,    w_ptr_nxt;
   logic [PW-1:0] r_owner,  w_owner_nxt;
   logic [7:0]    r_burst,  w_burst_nxt;
   logic [TW-1:0] r_to,     w_to_nxt;
   logic          r_last,   w_last_nxt;
   logic [N-1:0]  r_gnt,    w_gnt_nxt;
   logic [N-1:0]  r_ack,    w_ack_nxt;
   logic [7:0]    r_txdata, w_txdata_nxt;
   logic          r_txstb,  w_txstb_nxt;

   logic          w_any;
   logic [PW-1:0] w_win;
   logic          w_own_valid;
   logic          w_own_last;
   logic [7:0]    w_own_data;
   logic [TW-1:0] w_to_inc;

   // Owner's request lines, selected by the registered owner index.
   assign w_own_valid = reqValid[r_owner];
   assign w_own_last  = reqLast[r_owner];
   assign w_own_data  = reqData[8*r_owner +: 8];

   // Idle counter increment that saturates at TIMEOUT instead of wrapping.
   assign w_to_inc = (r_to >= TW'(TIMEOUT)) ? r_to : r_to + 1'b1;

   // Rotating-priority search: first valid requester from ptr+1 upward, mod N.
   // Scanning from the far end down lets the nearest candidate win last.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = N; k >= 1; k--) begin
         if (reqValid[(int'(r_ptr) + k) % N]) begin
            w_any = 1'b1;
            w_win = PW'((int'(r_ptr) + k) % N);
         end
      end
   end

   // Next-state and next-output logic for the IDLE/SEND/GUARD controller.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; otherwise synthesis would infer a latch.
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_owner_nxt  = r_owner;
      w_burst_nxt  = r_burst;
      w_to_nxt     = r_to;
      w_last_nxt   = r_last;
      w_gnt_nxt    = r_gnt;
      w_txdata_nxt = r_txdata;
      w_ack_nxt    = '0;
      w_txstb_nxt  = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_owner_nxt = w_win;
               w_gnt_nxt   = N'(1) << w_win;
               w_burst_nxt = '0;
               w_to_nxt    = '0;
               w_state_nxt = S_SEND;
            end
         end

         S_SEND: begin
            if (w_own_valid && txRdy) begin
               w_txdata_nxt = w_own_data;
               w_txstb_nxt  = 1'b1;
               w_ack_nxt    = r_gnt;
               w_burst_nxt  = r_burst + 8'd1;
               w_last_nxt   = w_own_last;
               w_state_nxt  = S_GUARD;
            end else if (!w_own_valid) begin
               w_to_nxt = w_to_inc;
               if (w_to_inc >= TW'(TIMEOUT)) begin
                  w_ptr_nxt   = r_owner;
                  w_gnt_nxt   = '0;
                  w_state_nxt = S_IDLE;
               end
            end
         end

         S_GUARD: begin
            w_to_nxt = '0;
            if (r_last || (r_burst == 8'(MAXBURST))) begin
               w_ptr_nxt   = r_owner;
               w_gnt_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_SEND;
            end
         end

         default: begin
            w_gnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge SYSCLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // updates from pre-edge values, independent of statement order.
      if (RESET) begin
         r_state  <= S_IDLE;
         r_ptr    <= PW'(N - 1);
         r_owner  <= '0;
         r_burst  <= '0;
         r_to     <= '0;
         r_last   <= 1'b0;
         r_gnt    <= '0;
         r_ack    <= '0;
         r_txdata <= 8'h00;
         r_txstb  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_owner  <= w_owner_nxt;
         r_burst  <= w_burst_nxt;
         r_to     <= w_to_nxt;
         r_last   <= w_last_nxt;
         r_gnt    <= w_gnt_nxt;
         r_ack    <= w_ack_nxt;
         r_txdata <= w_txdata_nxt;
         r_txstb  <= w_txstb_nxt;
      end
   end

   assign gnt    = r_gnt;
   assign reqAck = r_ack;
   assign txData = r_txdata;
   assign txStb  = r_txstb;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (N=4, MAXBURST=4, TIMEOUT=8).
// Requesters are modelled as byte queues; a single tick task advances the
// clock, logs strobes and presents the next byte after each acknowledge.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic           SYSCLK;
   logic           RESET;
   logic [8*N-1:0] reqData;
   logic [N-1:0]   reqValid;
   logic [N-1:0]   reqLast;
   logic [N-1:0]   reqAck;
   logic [N-1:0]   gnt;
   logic [7:0]     txData;
   logic           txStb;
   logic           txRdy;

   uart_tx_arbiter #(.N(N), .MAXBURST(4), .TIMEOUT(8)) dut (
      .SYSCLK   (SYSCLK),
      .RESET    (RESET),
      .reqData  (reqData),
      .reqValid (reqValid),
      .reqLast  (reqLast),
      .reqAck   (reqAck),
      .gnt      (gnt),
      .txData   (txData),
      .txStb    (txStb),
      .txRdy    (txRdy)
   );

   initial SYSCLK = 1'b0;
   always #5 SYSCLK = ~SYSCLK;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_b2b    = 0;
   int n_ackerr = 0;
   logic prev_stb = 1'b0;

   logic [8:0]   q[N][$];      // {last, data} per requester
   logic [N-1:0] hold = '0;    // force reqValid low while set
   logic [7:0]   ev_data[$];
   logic [N-1:0] ev_ack[$];
   int           ev_cyc[$];

   task automatic drive_inputs();
      logic [8:0] e;
      for (int i = 0; i < N; i++) begin
         if (q[i].size() > 0 && !hold[i]) begin
            e = q[i][0];
            reqValid[i]       = 1'b1;
            reqData[8*i +: 8] = e[7:0];
            reqLast[i]        = e[8];
         end else begin
            reqValid[i]       = 1'b0;
            reqData[8*i +: 8] = 8'h00;
            reqLast[i]        = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge SYSCLK);
      #1;
      cyc++;
      if (txStb) begin
         if (prev_stb) n_b2b++;
         ev_data.push_back(txData);
         ev_ack.push_back(reqAck);
         ev_cyc.push_back(cyc);
      end
      if (reqAck !== (txStb ? gnt : '0)) n_ackerr++;
      prev_stb = txStb;
      for (int i = 0; i < N; i++)
         if (reqAck[i] && q[i].size() > 0) void'(q[i].pop_front());
      drive_inputs();
   endtask

   task automatic clear_log();
      ev_data.delete();
      ev_ack.delete();
      ev_cyc.delete();
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) q[i].delete();
      hold  = '0;
      txRdy = 1'b1;
      RESET = 1'b1;
      drive_inputs();
      tick();
      tick();
      RESET = 1'b0;
      clear_log();
   endtask

   task automatic run_until_events(input int n, input int budget);
      for (int i = 0; i < budget && ev_data.size() < n; i++) tick();
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      txRdy = 1'b1;
      drive_inputs();
      tick();
      q[0].push_back({1'b1, 8'h5A});
      drive_inputs();
      tick();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      checks++; if (reqAck !== 4'b0000) begin failures++; $display("FAIL reset_ack: got %b expected 0000", reqAck); end
      checks++; if (txStb !== 1'b0) begin failures++; $display("FAIL reset_stb: got %b expected 0", txStb); end
      checks++; if (txData !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", txData); end
      RESET = 1'b0;
      tick();
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL reset_first_winner: got %b expected 0001", gnt); end
   endtask

   task automatic test_single_packet();
      int c0;
      do_reset();
      q[0].push_back({1'b0, 8'h41});
      q[0].push_back({1'b0, 8'h42});
      q[0].push_back({1'b1, 8'h43});
      drive_inputs();
      c0 = cyc;
      tick();
      checks++; if (gnt !== 4'b0001 || txStb !== 1'b0) begin failures++; $display("FAIL single_grant: got gnt=%b stb=%b expected 0001/0", gnt, txStb); end
      run_until_events(3, 20);
      checks++; if (ev_data.size() != 3) begin failures++; $display("FAIL single_count: got %0d expected 3", ev_data.size()); end
      for (int i = 0; i < 3; i++) begin
         logic [7:0]   d;
         logic [N-1:0] a;
         int           c;
         d = (i < ev_data.size()) ? ev_data[i] : 8'hxx;
         a = (i < ev_ack.size())  ? ev_ack[i]  : 'x;
         c = (i < ev_cyc.size())  ? ev_cyc[i]  : -1;
         checks++;
         if (d !== 8'h41 + 8'(i) || a !== 4'b0001 || c != c0 + 2 + 2*i) begin
            failures++;
            $display("FAIL single_byte%0d: got data=%h ack=%b cyc=%0d expected %h/0001/%0d",
                     i, d, a, c - c0, 8'h41 + 8'(i), 2 + 2*i);
         end
      end
      tick();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_release: got %b expected 0000", gnt); end
   endtask

   task automatic test_round_robin();
      logic [7:0]   exp_d1[4] = '{8'hA0, 8'hC0, 8'hA1, 8'hC1};
      logic [N-1:0] exp_a1[4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      logic [7:0]   exp_d2[4] = '{8'hB0, 8'hE1, 8'hD0, 8'hB1};
      logic [N-1:0] exp_a2[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
      do_reset();
      q[0].push_back({1'b1, 8'hA0});
      q[0].push_back({1'b1, 8'hA1});
      q[2].push_back({1'b1, 8'hC0});
      q[2].push_back({1'b1, 8'hC1});
      drive_inputs();
      run_until_events(4, 40);
      for (int i = 0; i < 4; i++) begin
         logic [7:0]   d;
         logic [N-1:0] a;
         d = (i < ev_data.size()) ? ev_data[i] : 8'hxx;
         a = (i < ev_ack.size())  ? ev_ack[i]  : 'x;
         checks++;
         if (d !== exp_d1[i] || a !== exp_a1[i]) begin
            failures++;
            $display("FAIL rr_pair%0d: got data=%h ack=%b expected %h/%b", i, d, a, exp_d1[i], exp_a1[i]);
         end
      end
      do_reset();
      q[0].push_back({1'b1, 8'hB0});
      q[0].push_back({1'b1, 8'hB1});
      q[2].push_back({1'b1, 8'hD0});
      drive_inputs();
      tick();
      q[1].push_back({1'b1, 8'hE1});
      drive_inputs();
      run_until_events(4, 40);
      for (int i = 0; i < 4; i++) begin
         logic [7:0]   d;
         logic [N-1:0] a;
         d = (i < ev_data.size()) ? ev_data[i] : 8'hxx;
         a = (i < ev_ack.size())  ? ev_ack[i]  : 'x;
         checks++;
         if (d !== exp_d2[i] || a !== exp_a2[i]) begin
            failures++;
            $display("FAIL rr_join%0d: got data=%h ack=%b expected %h/%b", i, d, a, exp_d2[i], exp_a2[i]);
         end
      end
   endtask

   task automatic test_burst();
      logic [7:0]   exp_d[11] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h14,
                                  8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
      logic [N-1:0] exp_a[11] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010,
                                  4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
      do_reset();
      for (int i = 0; i < 10; i++) q[1].push_back({1'b0, 8'h10 + 8'(i)});
      q[3].push_back({1'b1, 8'h30});
      drive_inputs();
      run_until_events(11, 80);
      checks++; if (ev_data.size() != 11) begin failures++; $display("FAIL burst_count: got %0d expected 11", ev_data.size()); end
      for (int i = 0; i < 11; i++) begin
         logic [7:0]   d;
         logic [N-1:0] a;
         d = (i < ev_data.size()) ? ev_data[i] : 8'hxx;
         a = (i < ev_ack.size())  ? ev_ack[i]  : 'x;
         checks++;
         if (d !== exp_d[i] || a !== exp_a[i]) begin
            failures++;
            $display("FAIL burst_byte%0d: got data=%h ack=%b expected %h/%b", i, d, a, exp_d[i], exp_a[i]);
         end
      end
      checks++;
      if (ev_cyc.size() < 5 || ev_cyc[4] - ev_cyc[3] != 3) begin
         failures++;
         $display("FAIL burst_handover_gap: got %0d expected 3", (ev_cyc.size() < 5) ? -1 : ev_cyc[4] - ev_cyc[3]);
      end
      for (int i = 0; i < 20 && gnt !== 4'b0000; i++) tick();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL burst_final_release: got %b expected 0000", gnt); end
   endtask

   task automatic test_timeout();
      int c0;
      do_reset();
      q[0].push_back({1'b0, 8'h50});
      q[2].push_back({1'b1, 8'h62});
      drive_inputs();
      c0 = cyc;
      tick();
      tick();
      checks++; if (txStb !== 1'b1 || txData !== 8'h50 || reqAck !== 4'b0001) begin failures++; $display("FAIL to_first_byte: got stb=%b data=%h ack=%b expected 1/50/0001", txStb, txData, reqAck); end
      while (cyc < c0 + 10) tick();
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL to_held_7_low: got %b expected 0001", gnt); end
      tick();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL to_release_8th_low: got %b expected 0000", gnt); end
      tick();
      checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL to_next_owner: got %b expected 0100", gnt); end
      tick();
      checks++; if (txStb !== 1'b1 || txData !== 8'h62 || reqAck !== 4'b0100) begin failures++; $display("FAIL to_next_byte: got stb=%b data=%h ack=%b expected 1/62/0100", txStb, txData, reqAck); end
   endtask

   task automatic test_stall();
      do_reset();
      txRdy = 1'b0;
      q[1].push_back({1'b1, 8'h77});
      drive_inputs();
      tick();
      checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL stall_grant: got %b expected 0010", gnt); end
      for (int i = 0; i < 20; i++) tick();
      checks++; if (ev_data.size() != 0) begin failures++; $display("FAIL stall_no_strobe: got %0d strobes expected 0", ev_data.size()); end
      checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL stall_no_timeout: got %b expected 0010", gnt); end
      txRdy = 1'b1;
      tick();
      checks++; if (txStb !== 1'b1 || txData !== 8'h77 || reqAck !== 4'b0010) begin failures++; $display("FAIL stall_release_byte: got stb=%b data=%h ack=%b expected 1/77/0010", txStb, txData, reqAck); end
      tick();
      checks++; if (txStb !== 1'b0 || txData !== 8'h77) begin failures++; $display("FAIL stall_data_hold: got stb=%b data=%h expected 0/77", txStb, txData); end
   endtask

   task automatic test_reset_in_guard();
      do_reset();
      q[0].push_back({1'b0, 8'h88});
      q[0].push_back({1'b1, 8'h89});
      drive_inputs();
      tick();
      tick();
      checks++; if (txStb !== 1'b1 || txData !== 8'h88) begin failures++; $display("FAIL guard_inflight: got stb=%b data=%h expected 1/88", txStb, txData); end
      RESET = 1'b1;
      q[2].push_back({1'b1, 8'h2A});
      drive_inputs();
      tick();
      checks++;
      if (gnt !== 4'b0000 || reqAck !== 4'b0000 || txStb !== 1'b0 || txData !== 8'h00) begin
         failures++;
         $display("FAIL guard_reset_values: got gnt=%b ack=%b stb=%b data=%h expected 0000/0000/0/00", gnt, reqAck, txStb, txData);
      end
      RESET = 1'b0;
      tick();
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL guard_first_after_reset: got %b expected 0001", gnt); end
      tick();
      checks++; if (txStb !== 1'b1 || txData !== 8'h89) begin failures++; $display("FAIL guard_resume_byte: got stb=%b data=%h expected 1/89", txStb, txData); end
   endtask

   task automatic test_protocol();
      checks++; if (n_b2b != 0) begin failures++; $display("FAIL proto_strobe_spacing: got %0d back-to-back strobes expected 0", n_b2b); end
      checks++; if (n_ackerr != 0) begin failures++; $display("FAIL proto_ack_vs_gnt: got %0d bad cycles expected 0", n_ackerr); end
   endtask

   initial begin
      RESET    = 1'b1;
      txRdy    = 1'b1;
      reqValid = '0;
      reqLast  = '0;
      reqData  = '0;
      test_reset();
      test_single_packet();
      test_round_robin();
      test_burst();
      test_timeout();
      test_stall();
      test_reset_in_guard();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `uart` transmitter (`txData`/`txStb`/`txRdy`) between N byte-stream requesters. It sits between the UART transmit port and the top-level producers, for example the echo path and debug/status streams. A requester that wins arbitration keeps ownership of the transmitter until it marks a byte `last`, exceeds a burst limit, or goes idle past a timeout. All outputs are registered.

## Interface
- `N`, 4: number of requesters (2..8).
- `MAXBURST`, 16: maximum bytes per grant before forced release (1..255).
- `TIMEOUT`, 1000: cycles the owner may hold `reqValid` low mid-packet before forced release (>=1).
- `SYSCLK` in 1: system clock; all logic on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `reqData` in 8*N: byte from requester i on `[8i+7:8i]`.
- `reqValid` in N: requester i has a byte presented.
- `reqLast` in N: the presented byte ends requester i's packet.
- `reqAck` out N: one-cycle one-hot pulse; the byte of requester i was taken.
- `gnt` out N: one-hot, current owner; all-zero when idle.
- `txData` out 8: byte to the UART.
- `txStb` out 1: one-cycle strobe to the UART.
- `txRdy` in 1: UART ready to accept a byte.

## Operation
- States: IDLE, SEND, GUARD.
- IDLE:
  - If any `reqValid` is set, select the first set bit searching from `ptr+1` upward, wrapping mod N.
  - Set `gnt` to the winner, clear `burstCnt` and `toCnt`, and go to SEND.
  - Otherwise stay in IDLE.
- SEND, owner `o`:
  - If `reqValid[o]` and `txRdy` are both set: on the edge, load `txData` with `reqData[o]`, set `txStb` to 1 and `reqAck` to one-hot `o`, increment `burstCnt`, and go to GUARD.
  - Else if `reqValid[o]` is low: increment `toCnt`. When `toCnt` reaches TIMEOUT, release.
  - Else (`reqValid[o]` high, `txRdy` low): `toCnt` holds and the state holds.
- GUARD (one cycle, `txRdy` ignored):
  - On the edge, clear `txStb` and `reqAck` to 0 and clear `toCnt`.
  - If the sent byte had `reqLast[o]` set (captured in SEND), or `burstCnt == MAXBURST`, release.
  - Otherwise go to SEND.
- Release: set `ptr` to o, clear `gnt` to 0, and go to IDLE.
- Non-owner requesters are never acked. Their `reqValid` is ignored until arbitration.
- `reqData`/`reqValid`/`reqLast` are sampled only in SEND. Requesters must update them on the edge that ends the `reqAck` cycle.

## Timing
- Reset values: state IDLE, `gnt`=0, `reqAck`=0, `txStb`=0, `txData`=8'h00, `ptr`=N-1 (requester 0 wins first), and both counters 0.
- Latency: `reqValid` sampled high in IDLE at edge k gives `gnt` high after edge k. With `txRdy` high, `txStb` and `reqAck` are high during the cycle after edge k+1.
- `txStb` is never high on two consecutive cycles.
- Minimum spacing between strobes is 2 cycles. In practice spacing is bounded by the UART's `txRdy`.
- `txData` is stable from the strobe cycle until the next strobe.
- Arbitration costs one IDLE cycle between owners, so there is no back-to-back grant change.
- A byte flagged `last` on the MAXBURST-th byte causes a single release.
- Simultaneous requests resolve by rotating priority. A requester whose `reqValid` drops while not owner loses nothing.
- Reset asserted in any state returns everything to the reset values on the next edge. A strobe in flight is cut to its current cycle only.
- Counter widths: `burstCnt` is 8 bits. `toCnt` is `$clog2(TIMEOUT+1)` bits and saturates; it never wraps.

## Test plan
- Single requester 0 sends a 3-byte packet 8'h41, 8'h42, 8'h43 (last on 8'h43) with `txRdy` tied high -> 3 `txStb` pulses 2 cycles apart carrying 41/42/43, 3 `reqAck[0]` pulses aligned with them, then `gnt` returns to 0.
- Requesters 0 and 2 request simultaneously, each with 1-byte packets repeated -> order 0, 2, 0, 2. After reset, requester 1 joining later is served before 0 wraps around again.
- MAXBURST=4, requester 1 streams 10 bytes without `last` while requester 3 waits -> 4 bytes from 1, then 1 from 3, then requester 1 resumes.
- TIMEOUT=8, owner drops `reqValid` mid-packet for 8 cycles while requester 2 waits -> `gnt` clears after the 8th low cycle and requester 2 is granted next.
- `txRdy` held low for 20 cycles in SEND -> no `txStb`, no `reqAck`, no timeout (owner valid). Byte goes out 1 cycle after `txRdy` rises.
- `RESET` asserted during GUARD -> next cycle all outputs at reset values. The following request from requester 0 is granted first.
